// File: rtl/jtpang_pkg.sv
// Shared constants for the Pang colour mixer: palette geometry and
// where each colour channel lives in a 16-bit palette entry.
package jtpang_pkg;

  localparam int PAL_AW = 10;
  localparam int PAL_N = 1 << PAL_AW;
  localparam logic [3:0] OBJ_TRANSP = 4'hF;

  // entry = {byte1, byte0}; byte1 = {x, R}, byte0 = {G, B}
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

endpackage

// File: rtl/jtpang_pal_ram.sv
// Palette RAM: two 1K x 8 byte lanes, CPU read/write on port A and
// a 16-bit video read on port B. Both ports are read-first.
module jtpang_pal_ram
  import jtpang_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic              cpu_rd,
  input  logic [PAL_AW:0]   cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_q,
  input  logic              vid_cen,
  input  logic [PAL_AW-1:0] vid_addr,
  output logic [15:0]       vid_q
);

  logic [7:0] lo [PAL_N];
  logic [7:0] hi [PAL_N];
  logic [PAL_AW-1:0] a;
  logic lane;

  assign a = cpu_addr[PAL_AW:1];
  assign lane = cpu_addr[0];

  always_ff @(posedge clk) begin
    if (cpu_we && !lane) lo[a] <= cpu_din;
    if (cpu_we && lane) hi[a] <= cpu_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_q <= '0;
      vid_q <= '0;
    end else begin
      if (cpu_rd) cpu_q <= lane ? hi[a] : lo[a];
      if (vid_cen) vid_q <= {hi[vid_addr], lo[vid_addr]};
    end
  end

endmodule

// File: rtl/jtpang_colmix.sv
// Final video stage: object/char priority, palette lookup, RGB and
// delayed blanking. Define JTPANG_LAYER_MASK_EN to honour gfx_en.
module jtpang_colmix
  import jtpang_pkg::*;
#(
  parameter int BLANK_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [7:0]  obj_pxl,
  input  logic [9:0]  char_pxl,
  input  logic        pal_cs,
  input  logic        cpu_wrn,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  pal_dout,
  input  logic [1:0]  gfx_en,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  logic obj_on;
  logic pxl_off;
  logic off_q;
  logic [PAL_AW-1:0] idx;
  logic [15:0] pal_q;
  logic [BLANK_DLY-1:0] hb_sr;
  logic [BLANK_DLY-1:0] vb_sr;

`ifndef JTPANG_LAYER_MASK_EN
  logic unused_gfx;
  assign unused_gfx = ^gfx_en;
`endif

  always_comb begin
    obj_on = obj_pxl[3:0] != OBJ_TRANSP;
    pxl_off = 1'b0;
`ifdef JTPANG_LAYER_MASK_EN
    obj_on = obj_on & gfx_en[1];
    pxl_off = !obj_on & !gfx_en[0];
`endif
    idx = obj_on ? {2'b00, obj_pxl} : char_pxl;
  end

  // stage 0 is the RAM's own video output register
  jtpang_pal_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .cpu_we   (pal_cs & ~cpu_wrn),
    .cpu_rd   (pal_cs & cpu_wrn),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_dout),
    .cpu_q    (pal_dout),
    .vid_cen  (pxl_cen),
    .vid_addr (idx),
    .vid_q    (pal_q)
  );

  assign LHBL_dly = hb_sr[BLANK_DLY-1];
  assign LVBL_dly = vb_sr[BLANK_DLY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q <= 1'b0;
      hb_sr <= '0;
      vb_sr <= '0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pxl_cen) begin
      off_q <= pxl_off;
      hb_sr <= {hb_sr[BLANK_DLY-2:0], LHBL};
      vb_sr <= {vb_sr[BLANK_DLY-2:0], LVBL};
      if (hb_sr[BLANK_DLY-2] && vb_sr[BLANK_DLY-2] && !off_q) begin
        red   <= pal_q[R_LSB+:4];
        green <= pal_q[G_LSB+:4];
        blue  <= pal_q[B_LSB+:4];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jtpang_colmix.sv
// Bench for jtpang_colmix: directed scenarios then random pixels and
// CPU traffic against a byte-array palette model.
module tb_jtpang_colmix;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pxl_cen = 1'b0;
  logic LHBL = 1'b0;
  logic LVBL = 1'b0;
  logic [7:0] obj_pxl = '0;
  logic [9:0] char_pxl = '0;
  logic pal_cs = 1'b0;
  logic cpu_wrn = 1'b1;
  logic [10:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0;
  logic [1:0] gfx_en = 2'b11;
  logic [7:0] pal_dout;
  logic [3:0] red, green, blue;
  logic LHBL_dly, LVBL_dly;

  int checks = 0;
  int failures = 0;

  logic [7:0] pal [2048];

  typedef struct packed {
    logic [11:0] rgb;
    logic hb;
    logic vb;
  } vout_t;

  vout_t pend[$];
  vout_t shown;

  always #5 clk = ~clk;

  jtpang_colmix dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .obj_pxl  (obj_pxl),
    .char_pxl (char_pxl),
    .pal_cs   (pal_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .gfx_en   (gfx_en),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  function automatic logic [11:0] model_rgb(logic [7:0] o, logic [9:0] c,
                                            logic hb, logic vb);
    int e;
    logic vis;
    if (!(hb && vb)) return 12'h000;
    vis = o[3:0] != 4'hF;
`ifdef JTPANG_LAYER_MASK_EN
    vis = vis && gfx_en[1];
    if (!vis && !gfx_en[0]) return 12'h000;
`endif
    e = vis ? int'(o) : int'(c);
    return {pal[2*e+1][3:0], pal[2*e][7:4], pal[2*e][3:0]};
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_video(string tag);
    check({tag, "_rgb"}, {4'h0, red, green, blue}, {4'h0, shown.rgb});
    check({tag, "_hb"}, {15'h0, LHBL_dly}, {15'h0, shown.hb});
    check({tag, "_vb"}, {15'h0, LVBL_dly}, {15'h0, shown.vb});
  endtask

  // one clk; optional pixel tick and optional simultaneous CPU write
  task automatic step(bit cen, logic [7:0] o, logic [9:0] c, bit hb, bit vb,
                      bit wr, logic [10:0] wa, logic [7:0] wd, string tag);
    vout_t e;
    pxl_cen = cen;
    obj_pxl = o;
    char_pxl = c;
    LHBL = hb;
    LVBL = vb;
    pal_cs = wr;
    cpu_wrn = !wr;
    cpu_addr = wa;
    cpu_dout = wd;
    if (cen) begin
      e.rgb = model_rgb(o, c, hb, vb);
      e.hb = hb;
      e.vb = vb;
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wr) pal[wa] = wd;
    pxl_cen = 1'b0;
    pal_cs = 1'b0;
    cpu_wrn = 1'b1;
    if (cen) shown = pend.pop_front();
    check_video(tag);
  endtask

  task automatic pix(logic [7:0] o, logic [9:0] c, bit hb, string tag);
    step(1'b1, o, c, hb, 1'b1, 1'b0, 11'h0, 8'h0, tag);
  endtask

  task automatic cpu_wr(logic [10:0] a, logic [7:0] d);
    step(1'b0, obj_pxl, char_pxl, LHBL, LVBL, 1'b1, a, d, "wr");
  endtask

  task automatic cpu_rd(logic [10:0] a, string tag);
    pal_cs = 1'b1;
    cpu_wrn = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    #1;
    pal_cs = 1'b0;
    check(tag, {8'h0, pal_dout}, {8'h0, pal[a]});
    cpu_addr = a ^ 11'h155;
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {8'h0, pal_dout}, {8'h0, pal[a]});
  endtask

  task automatic do_reset(string tag);
    pxl_cen = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({tag, "_rgb"}, {4'h0, red, green, blue}, 16'h0);
    check({tag, "_hb"}, {15'h0, LHBL_dly}, 16'h0);
    check({tag, "_vb"}, {15'h0, LVBL_dly}, 16'h0);
    check({tag, "_dout"}, {8'h0, pal_dout}, 16'h0);
    pend.delete();
    shown = '0;
    pend.push_back(shown);
  endtask

  initial begin
    logic [7:0] nb;
    do_reset("rst0");

    for (int a = 0; a < 2048; a++) cpu_wr(11'(a), 8'($urandom));

    // entry 1 via CPU bytes, opaque object
    cpu_wr(11'h002, 8'h0F);
    cpu_wr(11'h003, 8'h0A);
    pix(8'h01, 10'h3FF, 1'b1, "t1a");
    pix(8'h01, 10'h3FF, 1'b1, "t1b");
    check("t1_rgb", {4'h0, red, green, blue}, 16'h0A0F);

    // transparent object falls through to char
    cpu_wr(11'h20A, 8'h21);
    cpu_wr(11'h20B, 8'h07);
    pix(8'h3F, 10'h105, 1'b1, "t2a");
    pix(8'h3F, 10'h105, 1'b1, "t2b");
    check("t2_rgb", {4'h0, red, green, blue}, 16'h0721);

    // blanking two ticks later
    pix(8'h01, 10'h105, 1'b0, "t3a");
    pix(8'h01, 10'h105, 1'b1, "t3b");
    check("t3_rgb", {4'h0, red, green, blue}, 16'h0000);
    check("t3_hb", {15'h0, LHBL_dly}, 16'h0000);
    pix(8'h01, 10'h105, 1'b1, "t3c");
    check("t3_rgb_back", {4'h0, red, green, blue}, 16'h0A0F);

    // same-clk write and video read of entry 0x010: read-first
    nb = ~pal[11'h020];
    step(1'b1, 8'h10, 10'h0, 1'b1, 1'b1, 1'b1, 11'h020, nb, "t4a");
    pix(8'h10, 10'h0, 1'b1, "t4b");
    pix(8'h10, 10'h0, 1'b1, "t4c");
    check("t4_new_blue", {12'h0, blue}, {12'h0, nb[3:0]});
    cpu_rd(11'h020, "t4_rdback");

    // reset mid-line, palette survives
    pix(8'h01, 10'h0, 1'b1, "t5a");
    pix(8'h01, 10'h0, 1'b1, "t5b");
    do_reset("t5_rst");
    pix(8'h01, 10'h0, 1'b1, "t5c");
    pix(8'h01, 10'h0, 1'b1, "t5d");
    check("t5_rgb", {4'h0, red, green, blue}, 16'h0A0F);
    cpu_rd(11'h20A, "t5_pal_lo");
    cpu_rd(11'h20B, "t5_pal_hi");

`ifdef JTPANG_LAYER_MASK_EN
    gfx_en = 2'b01;
    pix(8'h01, 10'h105, 1'b1, "t6a");
    pix(8'h01, 10'h105, 1'b1, "t6b");
    check("t6_rgb", {4'h0, red, green, blue}, 16'h0721);
    gfx_en = 2'b10;
    pix(8'h3F, 10'h105, 1'b1, "t6c");
    pix(8'h3F, 10'h105, 1'b1, "t6d");
    check("t6_black", {4'h0, red, green, blue}, 16'h0000);
    gfx_en = 2'b11;
`endif

    for (int i = 0; i < 600; i++) begin
      bit cen, wr, hb, vb;
      logic [7:0] o;
      cen = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 4) == 0);
      hb = ($urandom_range(0, 7) != 0);
      vb = ($urandom_range(0, 9) != 0);
      o = 8'($urandom);
      if ($urandom_range(0, 2) == 0) o[3:0] = 4'hF;
`ifdef JTPANG_LAYER_MASK_EN
      if ($urandom_range(0, 7) == 0) gfx_en = 2'($urandom);
`endif
      step(cen, o, 10'($urandom), hb, vb, wr,
           11'($urandom), 8'($urandom), "rnd");
      if ($urandom_range(0, 15) == 0)
        cpu_rd(11'($urandom), "rnd_rd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
